// File: rtl/oscilo_pkg.sv
// Shared types and constants for the oscilloscope capture path.
// Holds the reader FSM encoding, header sync byte and default depth.
package oscilo_pkg;

    localparam int SAMPLE_DEPTH_DEF = 1024;
    localparam logic [7:0] HDR_SYNC = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        STREAM,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/sample_skid.sv
// Two-entry 8-bit FIFO that absorbs the sample memory read latency.
// Push and pop may coincide in any state, including when full.
module sample_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [1:0] count,
    output logic [7:0] head
);

    logic [7:0] mem_q [2];
    logic       rd_q;
    logic       wr_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= 8'd0;
            mem_q[1] <= 8'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/capture_reader.sv
// Streams a finished capture from circular memory to the host link.
// Define CAPTURE_READER_HEADER_EN to prefix each readout with 3 header bytes.
module capture_reader
    import oscilo_pkg::*;
#(
    parameter int SAMPLE_DEPTH = SAMPLE_DEPTH_DEF,
    parameter int ADDR_W       = $clog2(SAMPLE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] trig_offset,
    output logic              busy,
    output logic              done,
    output logic              m_re,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [7:0]        m_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(SAMPLE_DEPTH);
    localparam logic [ADDR_W:0]   LAST  = DEPTH - 1'b1;
    localparam logic [ADDR_W-1:0] HALF  = ADDR_W'(SAMPLE_DEPTH / 2);

    reader_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   reads_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;

    logic [1:0] count;
    logic [7:0] head;
    logic       pop;
    logic       push;
    logic [7:0] push_data;
    logic [2:0] occ;

    assign tx_valid = (count != 2'd0);
    assign tx_data  = head;
    assign pop      = tx_valid & tx_ready;
    // Entries the skid will hold once the current pop and in-flight read land.
    assign occ = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    assign m_re = (state_q == STREAM) && (reads_q != DEPTH) && (occ < 3'd2);

`ifdef CAPTURE_READER_HEADER_EN
    logic [ADDR_W-1:0] trig_q;
    logic [1:0]        hdr_cnt_q;
    logic [15:0]       t16;
    logic              hdr_push;
    logic [7:0]        hdr_byte;

    assign t16 = 16'(trig_q);

    always_comb begin
        hdr_push = 1'b0;
        hdr_byte = HDR_SYNC;
        if (state_q == IDLE) begin
            hdr_push = start & ~abort;
        end else if (state_q == HEADER) begin
            hdr_push = (hdr_cnt_q != 2'd3) && (occ < 3'd2) && !abort;
            hdr_byte = (hdr_cnt_q == 2'd1) ? t16[7:0] : t16[15:8];
        end
    end

    assign push      = inflight_q | hdr_push;
    assign push_data = inflight_q ? m_rdata : hdr_byte;
`else
    assign push      = inflight_q;
    assign push_data = m_rdata;
`endif

    sample_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            reads_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CAPTURE_READER_HEADER_EN
            trig_q     <= '0;
            hdr_cnt_q  <= 2'd0;
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= m_re;
            if (m_re) begin
                addr_q  <= addr_q + 1'b1;
                reads_q <= reads_q + 1'b1;
            end
            if (abort) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                inflight_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            busy_q  <= 1'b1;
                            addr_q  <= trig_offset - HALF;
                            reads_q <= '0;
`ifdef CAPTURE_READER_HEADER_EN
                            trig_q    <= trig_offset;
                            hdr_cnt_q <= 2'd1;
                            state_q   <= HEADER;
`else
                            state_q <= STREAM;
`endif
                        end
                    end
                    HEADER: begin
`ifdef CAPTURE_READER_HEADER_EN
                        if (hdr_push) begin
                            hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        end
                        if (hdr_cnt_q == 2'd3 && occ == 3'd0) begin
                            state_q <= STREAM;
                        end
`else
                        state_q <= IDLE;
`endif
                    end
                    STREAM: begin
                        if (m_re && reads_q == LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!inflight_q && occ == 3'd0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign m_addr = addr_q;

endmodule
